// File: rtl/sram_like_bridge_pkg.sv
// Shared encodings for the sram_like_bridge: FSM state codes, transfer size codes
// and the decoded write-enable bundle used by the data path.
package sram_like_bridge_pkg;

  localparam int STRB_W = 4;

  localparam logic [2:0] BR_IDLE    = 3'd0;
  localparam logic [2:0] BR_D_REQ   = 3'd1;
  localparam logic [2:0] BR_D_WAIT  = 3'd2;
  localparam logic [2:0] BR_I_REQ   = 3'd3;
  localparam logic [2:0] BR_I_WAIT  = 3'd4;
  localparam logic [2:0] BR_RELEASE = 3'd5;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [STRB_W-1:0] wstrb;
  } wen_dec_t;

  // Width of the bundled shared-port request: req, wr, size, wstrb, addr, wdata.
  function automatic int mem_port_wd(input int addr_w, input int data_w);
    return 1 + 1 + 2 + STRB_W + addr_w + data_w;
  endfunction

endpackage

// File: rtl/sram_like_bridge_if.sv
// Shared handshaked memory port: request side driven by the bridge (master),
// addr_ok/data_ok/rdata returned by the memory system (slave).
interface sram_like_bridge_if
  import sram_like_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  // Handshake: a request is held with all fields stable while mem_req=1 and is
  // accepted in the cycle mem_addr_ok=1; its completion is the later cycle with
  // mem_data_ok=1, when mem_rdata is valid for reads. One transaction outstanding.
  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [STRB_W-1:0] mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/sram_like_bridge_wen_size_dec.sv
// Combinational decode of core byte write enables into write flag, transfer
// size and byte strobes for the shared memory port.
module sram_like_bridge_wen_size_dec
  import sram_like_bridge_pkg::*;
(
  input  logic [STRB_W-1:0] i_wen,
  output wen_dec_t          o_dec
);

  always_comb begin
    o_dec.wr    = |i_wen;
    o_dec.wstrb = i_wen;
    // Irregular multi-byte patterns fall back to a word access.
    case (i_wen)
      4'b0000, 4'b1111:                   o_dec.size = SIZE_W;
      4'b0011, 4'b1100:                   o_dec.size = SIZE_H;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: o_dec.size = SIZE_B;
      default:                            o_dec.size = SIZE_W;
    endcase
  end

endmodule

// File: rtl/sram_like_bridge.sv
// Bridges the core's single-cycle inst/data SRAM ports onto one handshaked memory
// port, data access first, stalling the core until every access of the cycle is done.
module sram_like_bridge
  import sram_like_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_sram_en,
  input  logic [STRB_W-1:0] inst_sram_wen,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic [DATA_W-1:0] inst_sram_rdata,

  input  logic              data_sram_en,
  input  logic [STRB_W-1:0] data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,

  output logic              stallreq_mem,
  output logic [2:0]        dbg_state,

  sram_like_bridge_if.master mem
);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;

  logic              r_inst_en;
  logic              r_data_en;
  logic [ADDR_W-1:0] r_inst_addr;
  logic [ADDR_W-1:0] r_data_addr;
  logic [STRB_W-1:0] r_data_wen;
  logic [DATA_W-1:0] r_data_wdata;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;

  logic              w_any_en;
  logic              w_capture;
  logic              w_data_done;
  logic              w_inst_done;
  wen_dec_t          w_dec;

  // Fetch is always a read, so the inst write fields are intentionally dropped.
  logic              w_unused;
  assign w_unused = ^{inst_sram_wen, inst_sram_wdata};

  assign w_any_en    = inst_sram_en | data_sram_en;
  assign w_capture   = (r_state == BR_IDLE) && w_any_en;
  assign w_data_done = (r_state == BR_D_WAIT) && mem.mem_data_ok;
  assign w_inst_done = (r_state == BR_I_WAIT) && mem.mem_data_ok;

  sram_like_bridge_wen_size_dec u_wen_size_dec (
    .i_wen (r_data_wen),
    .o_dec (w_dec)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BR_IDLE:    if (w_any_en) w_state_nxt = data_sram_en ? BR_D_REQ : BR_I_REQ;
      BR_D_REQ:   if (mem.mem_addr_ok) w_state_nxt = BR_D_WAIT;
      BR_D_WAIT:  if (mem.mem_data_ok) w_state_nxt = r_inst_en ? BR_I_REQ : BR_RELEASE;
      BR_I_REQ:   if (mem.mem_addr_ok) w_state_nxt = BR_I_WAIT;
      BR_I_WAIT:  if (mem.mem_data_ok) w_state_nxt = BR_RELEASE;
      BR_RELEASE: w_state_nxt = BR_IDLE;
      default:    w_state_nxt = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BR_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The core's request is latched once in IDLE; later changes while stalled are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst_en    <= 1'b0;
      r_data_en    <= 1'b0;
      r_inst_addr  <= '0;
      r_data_addr  <= '0;
      r_data_wen   <= '0;
      r_data_wdata <= '0;
    end else if (w_capture) begin
      r_inst_en    <= inst_sram_en;
      r_data_en    <= data_sram_en;
      r_inst_addr  <= inst_sram_addr;
      r_data_addr  <= data_sram_addr;
      r_data_wen   <= data_sram_wen;
      r_data_wdata <= data_sram_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      if (w_data_done && r_data_en && !w_dec.wr) r_data_rdata <= mem.mem_rdata;
      if (w_inst_done) r_inst_rdata <= mem.mem_rdata;
    end
  end

  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_size  = SIZE_B;
    mem.mem_wstrb = '0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (r_state)
      BR_D_REQ: begin
        mem.mem_req   = 1'b1;
        mem.mem_wr    = w_dec.wr;
        mem.mem_size  = w_dec.size;
        mem.mem_wstrb = w_dec.wstrb;
        mem.mem_addr  = r_data_addr;
        mem.mem_wdata = r_data_wdata;
      end
      BR_I_REQ: begin
        mem.mem_req  = 1'b1;
        mem.mem_size = SIZE_W;
        mem.mem_addr = r_inst_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    stallreq_mem = 1'b0;
    case (r_state)
      BR_IDLE:                                     stallreq_mem = w_any_en;
      BR_D_REQ, BR_D_WAIT, BR_I_REQ, BR_I_WAIT:    stallreq_mem = 1'b1;
      default:                                     stallreq_mem = 1'b0;
    endcase
  end

  assign inst_sram_rdata = r_inst_rdata;
  assign data_sram_rdata = r_data_rdata;
  assign dbg_state       = r_state;

  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (mem.mem_req && !mem.mem_addr_ok) |=> (mem.mem_req &&
      $stable({mem.mem_wr, mem.mem_size, mem.mem_wstrb, mem.mem_addr, mem.mem_wdata})));

  a_release_once: assert property (@(posedge clk) disable iff (rst)
    (r_state == BR_RELEASE) |=> (r_state == BR_IDLE));

  a_state_legal: assert property (@(posedge clk) disable iff (rst)
    (r_state <= BR_RELEASE));

endmodule

// File: tb/tb_sram_like_bridge.sv
// Bench for sram_like_bridge: random core requests against a latency-randomised
// memory slave, checked by a transaction-level model of order, stall length and buffers.
module tb_sram_like_bridge;
  import sram_like_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_mem;
  logic [2:0]  dbg_state;

  sram_like_bridge_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq_mem    (stallreq_mem),
    .dbg_state       (dbg_state),
    .mem             (mem_bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [70:0] exp_q[$];     // expected {wr,size,wstrb,addr,wdata} in issue order
  logic [31:0] rd_q[$];      // read data the slave returned, in completion order
  logic [31:0] force_rd_q[$];
  logic [31:0] exp_ibuf = '0;
  logic [31:0] exp_dbuf = '0;
  int          exp_stall;
  int          last_stalls;

  function automatic logic [1:0] ref_size(input logic [3:0] wen);
    int ones;
    ones = $countones(wen);
    if (ones == 1) return 2'd0;
    if (ones == 2 && (wen == 4'b0011 || wen == 4'b1100)) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [70:0] bus_word();
    return {mem_bus.mem_wr, mem_bus.mem_size, mem_bus.mem_wstrb, mem_bus.mem_addr, mem_bus.mem_wdata};
  endfunction

  // ---------------- memory slave ----------------
  bit          slave_en   = 1'b1;
  bit          same_cycle = 1'b0;
  int          fix_a = -1;
  int          fix_d = -1;
  int          s_phase = 0;
  int          a_cnt, a_total, d_cnt;
  int          req_count = 0;
  logic [70:0] cur_req;
  logic [70:0] exp_word;

  initial begin
    mem_bus.mem_addr_ok = 1'b0;
    mem_bus.mem_data_ok = 1'b0;
    mem_bus.mem_rdata   = '0;
    forever begin
      @(negedge clk);
      if (!slave_en) begin
        s_phase = 0;
        continue;
      end
      mem_bus.mem_addr_ok = 1'b0;
      mem_bus.mem_data_ok = 1'b0;
      mem_bus.mem_rdata   = $urandom;
      if (rst) begin
        s_phase = 0;
        continue;
      end
      if (s_phase == 2) begin
        if (d_cnt == 0) begin
          mem_bus.mem_data_ok = 1'b1;
          mem_bus.mem_rdata   = (force_rd_q.size() > 0) ? force_rd_q.pop_front() : $urandom;
          rd_q.push_back(mem_bus.mem_rdata);
          s_phase = 0;
        end else begin
          d_cnt--;
        end
      end else begin
        if (s_phase == 0 && mem_bus.mem_req) begin
          req_count++;
          cur_req = bus_word();
          a_cnt   = (fix_a >= 0) ? fix_a : int'($urandom_range(0, 3));
          a_total = a_cnt;
          s_phase = 1;
        end
        if (s_phase == 1) begin
          check_eq("req_held", 128'(mem_bus.mem_req), 128'(1'b1));
          check_eq("req_fields_stable", 128'(bus_word()), 128'(cur_req));
          check_eq("stall_in_req", 128'(stallreq_mem), 128'(1'b1));
          if (a_cnt == 0) begin
            mem_bus.mem_addr_ok = 1'b1;
            check_eq("exp_q_avail", 128'(exp_q.size() > 0), 128'(1'b1));
            if (exp_q.size() > 0) begin
              exp_word = exp_q.pop_front();
              check_eq("req_fields", 128'(cur_req), 128'(exp_word));
            end
            d_cnt = (fix_d >= 0) ? fix_d : int'($urandom_range(0, 3));
            exp_stall += a_total + 1 + d_cnt + 1;
            if (same_cycle) mem_bus.mem_data_ok = 1'b1;
            s_phase = 2;
          end else begin
            a_cnt--;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  logic [3:0] wen_tab [8] = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  task automatic do_access(input bit ien, input bit den, input logic [3:0] wen,
                           input logic [31:0] iaddr, input logic [31:0] daddr,
                           input logic [31:0] wdata);
    int guard;
    int idx;
    int req0;
    @(negedge clk);
    exp_stall = 1;
    rd_q.delete();
    req0 = req_count;
    if (den) exp_q.push_back({|wen, ref_size(wen), wen, daddr, wdata});
    if (ien) exp_q.push_back({1'b0, 2'd2, 4'b0000, iaddr, 32'h0});
    inst_sram_en    = ien;
    inst_sram_wen   = 4'($urandom);
    inst_sram_addr  = iaddr;
    inst_sram_wdata = $urandom;
    data_sram_en    = den;
    data_sram_wen   = wen;
    data_sram_addr  = daddr;
    data_sram_wdata = wdata;
    #1;
    if (!(ien || den)) begin
      check_eq("idle_no_stall", 128'(stallreq_mem), 128'(1'b0));
      @(negedge clk);
      check_eq("idle_no_req", 128'(mem_bus.mem_req), 128'(1'b0));
      return;
    end
    last_stalls = 0;
    guard = 0;
    while (stallreq_mem === 1'b1 && guard < 300) begin
      last_stalls++;
      guard++;
      @(negedge clk);
      // The bridge must work from its captured copy, not the live core inputs.
      inst_sram_addr  = $urandom;
      data_sram_addr  = $urandom;
      data_sram_wdata = $urandom;
      data_sram_wen   = 4'($urandom);
      #1;
    end
    check_eq("no_timeout", 128'(guard < 300), 128'(1'b1));
    check_eq("stall_cycles", 128'(last_stalls), 128'(exp_stall));
    check_eq("all_reqs_issued", 128'(exp_q.size()), 128'(0));
    check_eq("req_count", 128'(req_count - req0), 128'(int'(ien) + int'(den)));
    check_eq("rd_count", 128'(rd_q.size()), 128'(int'(ien) + int'(den)));
    idx = 0;
    if (den && rd_q.size() > idx) begin
      if (wen == 4'b0000) exp_dbuf = rd_q[idx];
      idx++;
    end
    if (ien && rd_q.size() > idx) exp_ibuf = rd_q[idx];
    check_eq("inst_buf_release", 128'(inst_sram_rdata), 128'(exp_ibuf));
    check_eq("data_buf_release", 128'(data_sram_rdata), 128'(exp_dbuf));
    inst_sram_en = 1'b0;
    data_sram_en = 1'b0;
    @(negedge clk);
    check_eq("inst_buf_after", 128'(inst_sram_rdata), 128'(exp_ibuf));
    check_eq("data_buf_after", 128'(data_sram_rdata), 128'(exp_dbuf));
    check_eq("stall_low_after", 128'(stallreq_mem), 128'(1'b0));
  endtask

  task automatic random_accesses(input int n);
    for (int i = 0; i < n; i++) begin
      bit ien, den;
      ien = 1'($urandom);
      den = 1'($urandom);
      if (!ien && !den && ($urandom_range(0, 3) != 0)) ien = 1'b1;
      do_access(ien, den, wen_tab[$urandom_range(0, 7)], $urandom, $urandom, $urandom);
    end
  endtask

  task automatic reset_mid_fetch();
    int guard;
    fix_a = 0;
    fix_d = 20;
    @(negedge clk);
    exp_q.push_back({1'b0, 2'd2, 4'b0000, 32'hBFC00100, 32'h0});
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'hBFC00100;
    data_sram_en   = 1'b0;
    guard = 0;
    while (s_phase != 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("rst_reach_iwait", 128'(guard < 50), 128'(1'b1));
    @(negedge clk);
    slave_en            = 1'b0;
    rst                 = 1'b1;
    inst_sram_en        = 1'b0;
    mem_bus.mem_addr_ok = 1'b0;
    mem_bus.mem_data_ok = 1'b0;
    #1;
    check_eq("rst_mid_state", 128'(dbg_state), 128'(BR_IDLE));
    check_eq("rst_mid_req", 128'(mem_bus.mem_req), 128'(1'b0));
    check_eq("rst_mid_stall", 128'(stallreq_mem), 128'(1'b0));
    check_eq("rst_mid_ibuf", 128'(inst_sram_rdata), 128'(32'h0));
    check_eq("rst_mid_dbuf", 128'(data_sram_rdata), 128'(32'h0));
    @(negedge clk);
    rst                 = 1'b0;
    mem_bus.mem_data_ok = 1'b1;
    mem_bus.mem_rdata   = 32'hDEADBEEF;
    @(negedge clk);
    mem_bus.mem_data_ok = 1'b0;
    #1;
    check_eq("late_dok_state", 128'(dbg_state), 128'(BR_IDLE));
    check_eq("late_dok_ibuf", 128'(inst_sram_rdata), 128'(32'h0));
    check_eq("late_dok_dbuf", 128'(data_sram_rdata), 128'(32'h0));
    check_eq("late_dok_req", 128'(mem_bus.mem_req), 128'(1'b0));
    exp_ibuf = '0;
    exp_dbuf = '0;
    exp_q.delete();
    fix_a    = -1;
    fix_d    = -1;
    slave_en = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst             = 1'b1;
    inst_sram_en    = 1'b0;
    inst_sram_wen   = '0;
    inst_sram_addr  = '0;
    inst_sram_wdata = '0;
    data_sram_en    = 1'b0;
    data_sram_wen   = '0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", 128'(dbg_state), 128'(BR_IDLE));
    check_eq("reset_req", 128'(mem_bus.mem_req), 128'(1'b0));
    check_eq("reset_stall", 128'(stallreq_mem), 128'(1'b0));
    check_eq("reset_fields", 128'(bus_word()), 128'(71'h0));
    check_eq("reset_ibuf", 128'(inst_sram_rdata), 128'(32'h0));
    check_eq("reset_dbuf", 128'(data_sram_rdata), 128'(32'h0));
    rst = 1'b0;

    // Single fetch: accepted immediately, completion two cycles after accept.
    fix_a = 0;
    fix_d = 1;
    force_rd_q.push_back(32'h3C1D0001);
    do_access(1'b1, 1'b0, 4'b0000, 32'hBFC00000, 32'h0, 32'h0);
    check_eq("fetch_stall4", 128'(last_stalls), 128'(4));
    check_eq("fetch_data", 128'(inst_sram_rdata), 128'(32'h3C1D0001));

    // Load plus fetch in one cycle: data goes first.
    fix_a = -1;
    fix_d = -1;
    force_rd_q.push_back(32'h12345678);
    force_rd_q.push_back(32'h27BDFFE8);
    do_access(1'b1, 1'b1, 4'b0000, 32'hBFC00004, 32'h80001000, 32'h0);
    check_eq("load_data", 128'(data_sram_rdata), 128'(32'h12345678));
    check_eq("load_fetch_inst", 128'(inst_sram_rdata), 128'(32'h27BDFFE8));

    // Byte store leaves the load buffer alone.
    do_access(1'b0, 1'b1, 4'b0100, 32'h0, 32'h80000002, 32'h00AB0000);
    check_eq("store_dbuf_kept", 128'(data_sram_rdata), 128'(32'h12345678));

    // addr_ok back-pressure for 5 cycles.
    fix_a = 5;
    fix_d = 0;
    do_access(1'b0, 1'b1, 4'b1111, 32'h0, 32'h80002000, 32'hCAFEF00D);
    do_access(1'b1, 1'b1, 4'b0011, 32'hBFC00008, 32'h80002004, 32'h0000BEEF);

    // data_ok already high in the accept cycle.
    fix_a = 0;
    fix_d = 0;
    same_cycle = 1'b1;
    do_access(1'b0, 1'b1, 4'b0000, 32'h0, 32'h80003000, 32'h0);
    do_access(1'b1, 1'b1, 4'b0000, 32'hBFC0000C, 32'h80003004, 32'h0);
    same_cycle = 1'b0;
    fix_a = -1;
    fix_d = -1;

    random_accesses(30);
    reset_mid_fetch();
    random_accesses(15);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_like_bridge.md
Name: sram_like_bridge

Overview:
- Sits between the CPU core's inst_sram/data_sram ports (single-cycle en/wen style) and one shared handshaked memory port (req/addr_ok/data_ok).
- Captures the core's per-cycle instruction and data requests and serialises them, data first, onto the shared port with one transaction outstanding.
- Raises a stall request to CTRL until every enabled access of the current cycle has completed.
- Returns read data from hold buffers, so the core sees fixed-latency SRAM semantics.

Parameters:
- ADDR_W, 32, address width of core and memory ports.
- DATA_W, 32, data width; wen/wstrb width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- inst_sram_en  in  1  instruction fetch enable
- inst_sram_wen  in  4  ignored; fetch is always a read
- inst_sram_addr  in  ADDR_W  fetch address
- inst_sram_wdata  in  DATA_W  ignored
- inst_sram_rdata  out  DATA_W  fetched instruction (hold buffer)
- data_sram_en  in  1  data access enable
- data_sram_wen  in  4  byte write enables; 0000 means read
- data_sram_addr  in  ADDR_W  data address
- data_sram_wdata  in  DATA_W  store data
- data_sram_rdata  out  DATA_W  load data (hold buffer)
- stallreq_mem  out  1  stall request to CTRL
- mem_req  out  1  shared-port request valid
- mem_wr  out  1  1 = write
- mem_size  out  2  0 = byte, 1 = half, 2 = word
- mem_wstrb  out  4  byte strobes
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_addr_ok  in  1  request accepted this cycle
- mem_data_ok  in  1  response/completion this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_data_ok

Behaviour:
- Reset values: state = IDLE. All capture registers and both rdata buffers = 0. mem_req = 0, stallreq_mem = 0, all other mem_* outputs = 0.
- Reset is asynchronous. Asserting rst mid-transaction aborts to IDLE. A late mem_data_ok after reset is ignored because it is only sampled in the WAIT states.
- States: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, RELEASE.
- IDLE:
  - If inst_sram_en or data_sram_en, register en flags, addresses, data_sram_wen and data_sram_wdata.
  - Go to D_REQ if data is enabled, else I_REQ.
  - stallreq_mem is combinationally 1 in this cycle whenever either en is 1.
- D_REQ:
  - mem_req = 1 with registered data fields; hold fields stable until accepted.
  - mem_wr = |wen; mem_wstrb = wen.
  - mem_size from wen: 1111 or 0000 -> 2; 0011 or 1100 -> 1; one-hot -> 0.
  - On mem_addr_ok go to D_WAIT.
- D_WAIT:
  - mem_req = 0.
  - On mem_data_ok: if the access is a read, load the data buffer from mem_rdata.
  - Then go to I_REQ if inst is pending, else RELEASE.
- I_REQ / I_WAIT:
  - Same protocol with mem_wr = 0, mem_size = 2, mem_wstrb = 0000.
  - The inst buffer loads on mem_data_ok, then go to RELEASE.
- RELEASE:
  - stallreq_mem = 0 for exactly one cycle, so the pipeline advances. Next state is IDLE.
- stallreq_mem = 1 in D_REQ, D_WAIT, I_REQ and I_WAIT.
- rdata buffers change only on mem_data_ok. They stay valid through RELEASE and the following cycle.
- mem_addr_ok and mem_data_ok in the same cycle while in a REQ state: treat as accept, then completion next cycle. The slave guarantees data_ok never precedes addr_ok.
- Minimum access cost:
  - Data-only or inst-only: 1 stall cycle in IDLE, plus REQ, WAIT, RELEASE.
  - Both enabled: add 2 further cycles.
- Requests are not re-issued while stalled. Capture happens only in IDLE.

Decomposition:
- defines.vh gains:
  - state encodings (`BR_IDLE … `BR_RELEASE);
  - size codes (`SIZE_B/H/W);
  - `MEM_PORT_WD, the bundled shared-port width.
- One natural sub-module, wen_size_dec: combinational wen -> {wr, size, wstrb}.

Test Plan:
- Reset mid-operation: rst asserted in I_WAIT -> next cycle IDLE, mem_req = 0, stallreq_mem = 0, both buffers 0. A subsequent data_ok = 1 is ignored.
- Single fetch: inst_en = 1, addr 0xBFC00000; slave addr_ok in 1 cycle, data_ok 2 cycles later with 0x3C1D0001 -> stall held 4 cycles, then 1 low cycle; inst_sram_rdata = 0x3C1D0001.
- Load plus fetch in one cycle: data_en = 1, wen 0000, addr 0x80001000 -> mem_rdata 0x12345678; then inst fetch -> data transaction issued first; both buffers correct; stall deasserts once.
- Byte store: wen 0100, addr 0x80000002, wdata 0x00AB0000 -> mem_wr = 1, mem_size = 0, mem_wstrb = 0100, data buffer unchanged.
- addr_ok back-pressure: hold addr_ok = 0 for 5 cycles -> mem_req and all fields stable for 6 cycles; stall stays 1.
- Same-cycle handshake: addr_ok = 1 in D_REQ, data_ok already high -> one transaction counted only; no duplicate request.
